switch_conditioner: RTL

Upstream input-conditioning stage for the player switch buses (`switches_p1` / `switches_p2`) consumed by the display and game logic. It takes raw, asynchronous, bouncing switch levels and produces clean debounced levels. It also produces single-cycle press and release pulses, plus sticky press flags that game logic clears explicitly. One instance is used per player.

---
 rtl/switch_conditioner.sv | 82 ++++++++
 1 files changed

// File: rtl/switch_conditioner.sv
// Raw switch conditioner: 2-flop synchronizer, shared tick prescaler, per-bit
// debounce counters, registered press/release pulses and sticky press flags.
module switch_conditioner #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned PRESCALE     = 256,
  parameter int unsigned STABLE_TICKS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic [WIDTH-1:0] ack_mask,
  output logic [WIDTH-1:0] sw_level,
  output logic [WIDTH-1:0] sw_press,
  output logic [WIDTH-1:0] sw_release,
  output logic [WIDTH-1:0] sw_latched
);

  localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int unsigned CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [PW-1:0]    pre_cnt;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  logic [WIDTH-1:0] level_next;
  logic [WIDTH-1:0] press_next;
  logic [WIDTH-1:0] release_next;
  logic [WIDTH-1:0] latched_next;
  logic             tick_c;

  assign tick_c = (pre_cnt == PRE_LAST);

  // Debounce decision per bit; a matching sample always discards partial counts.
  always_comb begin
    level_next = sw_level;
    cnt_next   = cnt;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync2[i] == sw_level[i]) begin
        cnt_next[i] = '0;
      end else if (tick_c && (cnt[i] == CNT_LAST)) begin
        level_next[i] = sync2[i];
        cnt_next[i]   = '0;
      end else if (tick_c) begin
        cnt_next[i] = CW'(cnt[i] + CW'(1));
      end
    end
    press_next   = level_next & ~sw_level;
    release_next = ~level_next & sw_level;
    // Set wins over a same-edge acknowledge.
    latched_next = (sw_latched & ~ack_mask) | press_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= '0;
      sync2      <= '0;
      pre_cnt    <= '0;
      sw_level   <= '0;
      sw_press   <= '0;
      sw_release <= '0;
      sw_latched <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1      <= sw_raw;
      sync2      <= sync1;
      pre_cnt    <= tick_c ? '0 : PW'(pre_cnt + PW'(1));
      sw_level   <= level_next;
      sw_press   <= press_next;
      sw_release <= release_next;
      sw_latched <= latched_next;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

endmodule
